// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter granting one of N sources onto a shared tri-state bus.
// Each grant is one burst (up to MAX_BURST beats) followed by a dead TURN cycle.
module tri_bus_arbiter_lane #(
   parameter int W = 8
) (
   input  logic         gnt,
   input  logic         req,
   input  logic         rdy,
   input  logic [W-1:0] din,
   output logic         vld,
   output logic         pop,
   output logic [W-1:0] data
);
   assign vld  = gnt & req;
   assign pop  = vld & rdy;
   assign data = din & {W{gnt}};
endmodule

module tri_bus_arbiter #(
   parameter int N         = 4,
   parameter int W         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] din,
   input  logic           rdy,
   output tri   [W-1:0]   bus,
   output logic           bus_valid,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   pop
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

   state_t                state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         g_idx;
   logic [BW-1:0]         beat_cnt;
   logic [N-1:0]          lane_vld;
   logic [N-1:0][W-1:0]   lane_data;
   logic [W-1:0]          bus_data;
   logic [N-1:0]          pick_oh;
   logic [PW-1:0]         pick_idx;
   logic                  any_pop;
   logic                  last_beat;

   for (genvar i = 0; i < N; i++) begin : g_lane
      tri_bus_arbiter_lane #(.W(W)) u_lane (
         .gnt  (gnt[i]),
         .req  (req[i]),
         .rdy  (rdy),
         .din  (din[i*W +: W]),
         .vld  (lane_vld[i]),
         .pop  (pop[i]),
         .data (lane_data[i])
      );
   end

   // gnt is one-hot (or zero), so an OR of the masked lanes is the mux
   always_comb begin
      bus_data = '0;
      for (int i = 0; i < N; i++) bus_data = bus_data | lane_data[i];
   end

   assign bus_valid = |lane_vld;
   assign any_pop   = |pop;
   assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
   assign bus       = (state == DRIVE) ? bus_data : {W{1'bz}};

   // first requester at or above ptr, wrapping modulo N
   always_comb begin
      int  j;
      logic found;
      pick_oh  = '0;
      pick_idx = '0;
      found    = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found       = 1'b1;
            pick_oh[j]  = 1'b1;
            pick_idx    = PW'(j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         ptr      <= '0;
         g_idx    <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (|req) begin
               gnt      <= pick_oh;
               g_idx    <= pick_idx;
               beat_cnt <= '0;
               state    <= DRIVE;
            end
            DRIVE: begin
               if (!bus_valid || (any_pop && last_beat)) begin
                  gnt   <= '0;
                  state <= TURN;
               end else if (any_pop) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            TURN: begin
               ptr   <= (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
               state <= IDLE;
            end
            default: begin
               gnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=4, W=8, MAX_BURST=4); bus is pulled
// high in the bench so an undriven bus reads as 8'hFF.
module tb_tri_bus_arbiter;
   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] din;
   logic        rdy;
   tri1  [7:0]  bus;
   logic        bus_valid;
   logic [3:0]  gnt;
   logic [3:0]  pop;

   int errors;
   int checks;

   tri_bus_arbiter #(.N(4), .W(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .din       (din),
      .rdy       (rdy),
      .bus       (bus),
      .bus_valid (bus_valid),
      .gnt       (gnt),
      .pop       (pop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int s);
      logic [3:0] v;
      v = 4'b0001 << s;
      return v;
   endfunction

   initial begin
      logic [5:0] stall_pat;
      int s;
      int idx;
      errors = 0; checks = 0;
      rst_n = 1'b0; req = '0; rdy = 1'b0; din = '0;
      #2;
      chk("rst_gnt", gnt, 0);
      chk("rst_valid", bus_valid, 0);
      chk("rst_pop", pop, 0);
      chk("rst_bus", bus, 8'hFF);
      cyc; rst_n = 1'b1; cyc;

      // single source, req drops after three pops
      req = 4'b0001; rdy = 1'b1; din[7:0] = 8'hA1; #1;
      chk("a_idle_gnt", gnt, 0);
      chk("a_idle_bus", bus, 8'hFF);
      cyc;
      for (int b = 0; b < 3; b++) begin
         din[7:0] = 8'hA1 + 8'(b); #1;
         chk("a_gnt", gnt, 4'b0001);
         chk("a_pop", pop, 4'b0001);
         chk("a_bus", bus, 8'hA1 + 8'(b));
         chk("a_valid", bus_valid, 1);
         cyc;
      end
      req = 4'b0000; #1;
      chk("a_drop_valid", bus_valid, 0);
      chk("a_drop_pop", pop, 0);
      chk("a_drop_gnt", gnt, 4'b0001);
      chk("a_drop_bus", bus, 8'hA3);
      cyc; #1;
      chk("a_turn_gnt", gnt, 0);
      chk("a_turn_bus", bus, 8'hFF);
      chk("a_turn_valid", bus_valid, 0);
      cyc;

      // round robin from ptr=1 with all sources requesting
      din = 32'h40302010; req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         s = (1 + k) % 4;
         #1;
         chk("rr_idle_gnt", gnt, 0);
         chk("rr_idle_bus", bus, 8'hFF);
         cyc;
         for (int b = 0; b < 4; b++) begin
            #1;
            chk("rr_gnt", gnt, oh(s));
            chk("rr_pop", pop, oh(s));
            chk("rr_bus", bus, 32'((s + 1) * 16));
            chk("rr_valid", bus_valid, 1);
            cyc;
         end
         #1;
         chk("rr_turn_gnt", gnt, 0);
         chk("rr_turn_bus", bus, 8'hFF);
         chk("rr_turn_valid", bus_valid, 0);
         cyc;
      end
      req = 4'b0000;

      // burst cap and re-grant of a lone requester (ptr=2)
      req = 4'b0100; din[23:16] = 8'h77; #1;
      chk("cap_idle_gnt", gnt, 0);
      cyc;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk("cap_pop", pop, 4'b0100);
         chk("cap_bus", bus, 8'h77);
         cyc;
      end
      #1;
      chk("cap_turn_gnt", gnt, 0);
      chk("cap_turn_bus", bus, 8'hFF);
      cyc; #1;
      chk("cap_idle2_gnt", gnt, 0);
      chk("cap_idle2_bus", bus, 8'hFF);
      cyc; #1;
      chk("cap_regnt", gnt, 4'b0100);
      chk("cap_regnt_pop", pop, 4'b0100);
      req = 4'b0000; #1;
      chk("cap_drop_valid", bus_valid, 0);
      cyc; cyc;

      // stall on source 1 (ptr=3): pops 1,0,0,1 then two more reach the cap
      req = 4'b0010; din[15:8] = 8'h55; rdy = 1'b1; #1;
      chk("st_idle_gnt", gnt, 0);
      cyc;
      stall_pat = 6'b111001;
      for (int i = 0; i < 6; i++) begin
         rdy = stall_pat[i]; #1;
         chk("st_pop", pop, stall_pat[i] ? 4'b0010 : 4'b0000);
         chk("st_bus", bus, 8'h55);
         chk("st_valid", bus_valid, 1);
         chk("st_gnt", gnt, 4'b0010);
         cyc;
      end
      #1;
      chk("st_turn_gnt", gnt, 0);
      chk("st_turn_bus", bus, 8'hFF);
      cyc;
      req = 4'b0000;

      // asynchronous reset mid-burst of source 3 (ptr=2)
      req = 4'b1000; din[31:24] = 8'h99; rdy = 1'b1; #1;
      chk("rs_idle_gnt", gnt, 0);
      cyc; #1;
      chk("rs_gnt", gnt, 4'b1000);
      chk("rs_bus", bus, 8'h99);
      #1; rst_n = 1'b0; #1;
      chk("rs_async_gnt", gnt, 0);
      chk("rs_async_bus", bus, 8'hFF);
      chk("rs_async_valid", bus_valid, 0);
      chk("rs_async_pop", pop, 0);
      cyc;
      rst_n = 1'b1; req = 4'b1010; #1;
      chk("rs_rel_gnt", gnt, 0);
      cyc; #1;
      chk("rs_ptr0_gnt", gnt, 4'b0010);
      req = 4'b0000;
      cyc; cyc; cyc;

      // random traffic: no X on bus, one-hot grants, pops carry the right word
      for (int c = 0; c < 2000; c++) begin
         req = 4'($urandom_range(0, 15));
         rdy = 1'($urandom_range(0, 1));
         din = $urandom;
         #1;
         chk("cont_x", $isunknown(bus), 0);
         chk("cont_onehot", $onehot0(gnt), 1);
         chk("cont_pop_sub", pop & ~gnt, 0);
         if (gnt == 4'b0000) chk("cont_undriven", bus, 8'hFF);
         if (|pop) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (pop[i]) idx = i;
            chk("cont_data", bus, din[idx*8 +: 8]);
         end
         cyc;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
